// File: rtl/player_texture_loader.sv
// Texture loader for the player sprite: buffers packed pixel-pair words in a small FIFO
// and replays them as single-pixel writes into the sprite RAM, only during vertical blank.
module player_texture_loader #(
    parameter int pColorDepth   = 16,
    parameter int pRamDepth     = 2048,
    parameter int pRamAdrsWidth = 11,
    parameter int pFifoDepth    = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iStart,
    input  logic [pRamAdrsWidth:0]     iLoadLen,
    input  logic [2*pColorDepth-1:0]   iWd,
    input  logic                       iWdVd,
    output logic                       oWdRdy,
    input  logic                       iVblank,
    output logic [pColorDepth-1:0]     oPlayerPixelWd,
    output logic                       oPlayerPixelWe,
    output logic                       oPDRst,
    output logic                       oBusy,
    output logic                       oDone,
    output logic                       oErr
);

    localparam int AW  = pRamAdrsWidth;
    localparam int CD  = pColorDepth;
    localparam int FAW = $clog2(pFifoDepth);

    localparam logic [AW:0]  RAM_DEPTH = (AW+1)'(pRamDepth);
    localparam logic [AW:0]  CNT_ONE   = (AW+1)'(1);
    localparam logic [FAW:0] PTR_ONE   = (FAW+1)'(1);

    // IDLE: wait for start | CLR: reset draw address, flush | LOAD: stream pixels | DONE: completion pulse
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW:0]      need_q, need_d;
    logic [AW:0]      acc_q, acc_d;
    logic [AW:0]      pix_q, pix_d;
    logic             half_q, half_d;
    logic [FAW:0]     wr_ptr_q, wr_ptr_d;
    logic [FAW:0]     rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [CD-1:0]    wd_q, wd_d;

    logic [2*CD-1:0]  mem_q [pFifoDepth];
    logic [2*CD-1:0]  rd_word;

    logic             fifo_full;
    logic             fifo_empty;
    logic             wd_rdy;
    logic             push;
    logic             emit;
    logic             last_pix;
    logic             pop;
    logic             start_bad;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                        (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
    assign rd_word    = mem_q[rd_ptr_q[FAW-1:0]];

    // Ready comes from registered state only, so it can never combinationally loop on iWdVd.
    assign wd_rdy   = (state_q == ST_LOAD) && !fifo_full && (acc_q < need_q);
    assign push     = iWdVd && wd_rdy;
    assign emit     = (state_q == ST_LOAD) && !fifo_empty && iVblank && (pix_q < len_q);
    assign last_pix = ((pix_q + CNT_ONE) == len_q);
    assign pop      = emit && (half_q || last_pix);

    assign start_bad = (iLoadLen == '0) || (iLoadLen > RAM_DEPTH);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        need_d   = need_q;
        acc_d    = acc_q;
        pix_d    = pix_q;
        half_d   = half_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        we_d     = 1'b0;
        wd_d     = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = iLoadLen;
                        err_d   = 1'b0;
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                acc_d    = '0;
                pix_d    = '0;
                half_d   = 1'b0;
                need_d   = {1'b0, len_q[AW:1]} + {{AW{1'b0}}, len_q[0]};
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    acc_d    = acc_q + CNT_ONE;
                end
                if (emit) begin
                    we_d  = 1'b1;
                    wd_d  = half_q ? rd_word[2*CD-1:CD] : rd_word[CD-1:0];
                    pix_d = pix_q + CNT_ONE;
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        half_d   = 1'b0;
                    end else begin
                        half_d   = 1'b1;
                    end
                end
                // Done is entered one cycle after the final write so it trails the last strobe.
                if (pix_q == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            need_q   <= '0;
            acc_q    <= '0;
            pix_q    <= '0;
            half_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            need_q   <= need_d;
            acc_q    <= acc_d;
            pix_q    <= pix_d;
            half_q   <= half_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            we_q     <= we_d;
            wd_q     <= wd_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_q[wr_ptr_q[FAW-1:0]] <= iWd;
        end
    end

    assign oWdRdy         = wd_rdy;
    assign oPlayerPixelWe = we_q;
    assign oPlayerPixelWd = wd_q;
    assign oPDRst         = (state_q == ST_CLR);
    assign oBusy          = (state_q != ST_IDLE);
    assign oDone          = (state_q == ST_DONE);
    assign oErr           = err_q;

endmodule

// File: tb/tb_player_texture_loader.sv
// Self-checking bench for player_texture_loader: randomized loads compared against a
// pixel-list model built directly from the packed words.
module tb_player_texture_loader;

    localparam int CD = 16;
    localparam int RD = 2048;
    localparam int AW = 11;
    localparam int FD = 4;

    logic            iCLK = 1'b0;
    logic            iRST;
    logic            iStart;
    logic [AW:0]     iLoadLen;
    logic [2*CD-1:0] iWd;
    logic            iWdVd;
    logic            oWdRdy;
    logic            iVblank;
    logic [CD-1:0]   oPlayerPixelWd;
    logic            oPlayerPixelWe;
    logic            oPDRst;
    logic            oBusy;
    logic            oDone;
    logic            oErr;

    player_texture_loader #(
        .pColorDepth(CD), .pRamDepth(RD), .pRamAdrsWidth(AW), .pFifoDepth(FD)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iLoadLen(iLoadLen),
        .iWd(iWd), .iWdVd(iWdVd), .oWdRdy(oWdRdy), .iVblank(iVblank),
        .oPlayerPixelWd(oPlayerPixelWd), .oPlayerPixelWe(oPlayerPixelWe),
        .oPDRst(oPDRst), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    always @(posedge iCLK) cyc++;

    logic [CD-1:0]   wr_q[$];
    logic [2*CD-1:0] words[$];
    int  pdrst_cnt = 0;
    int  done_cnt = 0;
    int  last_we_cyc = -1;
    int  first_we_cyc = -1;
    int  done_cyc = -1;
    int  gap_viol = 0;
    logic prev_vb = 1'b1;

    // Monitor: write strobes must only follow an edge that saw iVblank high.
    always @(negedge iCLK) begin
        if (oPlayerPixelWe) begin
            if (wr_q.size() == 0) first_we_cyc = cyc;
            wr_q.push_back(oPlayerPixelWd);
            last_we_cyc = cyc;
            if (!prev_vb) gap_viol++;
        end
        if (oPDRst) pdrst_cnt++;
        if (oDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_vb = iVblank;
    end

    // Reference: pixel i is half (i % 2) of word i / 2, low half first.
    function automatic logic [CD-1:0] exp_px(input int i);
        logic [2*CD-1:0] w;
        w = words[i/2];
        return (i % 2 == 1) ? w[2*CD-1:CD] : w[CD-1:0];
    endfunction

    function automatic int first_bad(input int len);
        for (int i = 0; i < len; i++) begin
            if (i >= wr_q.size()) return i;
            if (wr_q[i] !== exp_px(i)) return i;
        end
        if (wr_q.size() != len) return len;
        return -1;
    endfunction

    task automatic fill_random(input int nwords);
        words.delete();
        for (int i = 0; i < nwords; i++) words.push_back($urandom);
    endtask

    // Stimulus driver only; observations are returned to the calling test for checking.
    // mode 0: vblank always high, 1: random vblank, 2: 10-cycle gap after first pixel.
    task automatic do_load(input int len, input int mode, input bit busy_start, input int stop_px,
                           output bit timeout, output bit clr_ok, output int rdy_viol,
                           output bit gap_rdy, output int gap_fill, output int lat);
        int  idx;
        int  gap_left;
        int  loops;
        int  acc_edge;
        bit  accepted;
        bit  gap_started;
        int  d0;
        idx = 0; gap_left = 0; loops = 0; acc_edge = -1; gap_started = 0;
        timeout = 0; clr_ok = 0; rdy_viol = 0; gap_rdy = 1'b1; gap_fill = -1; lat = -1;
        wr_q.delete();
        first_we_cyc = -1;
        d0 = done_cnt;
        @(posedge iCLK); #1;
        iStart = 1'b1; iLoadLen = (AW+1)'(len); iVblank = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        iWdVd = (words.size() > 0);
        if (iWdVd) iWd = words[0];
        @(negedge iCLK); #1;
        clr_ok = (oPDRst === 1'b1) && (oBusy === 1'b1) && (oWdRdy === 1'b0);
        while (1) begin
            if (idx >= words.size() && oWdRdy === 1'b1) rdy_viol++;
            if (mode == 2 && gap_left == 1) begin
                gap_rdy  = oWdRdy;
                gap_fill = idx - wr_q.size() / 2;
            end
            accepted = iWdVd && oWdRdy;
            if (stop_px != 0 && wr_q.size() >= stop_px) break;
            if (done_cnt != d0) break;
            if (loops > 6000) begin
                timeout = 1;
                break;
            end
            if (accepted && acc_edge < 0) acc_edge = cyc + 1;
            @(posedge iCLK); #1;
            loops++;
            if (accepted) idx++;
            iWdVd = (idx < words.size());
            if (iWdVd) iWd = words[idx];
            iStart = busy_start && (loops == 3);
            iLoadLen = (AW+1)'(5);
            if (mode == 0) begin
                iVblank = 1'b1;
            end else if (mode == 1) begin
                iVblank = ($urandom_range(3) != 0);
            end else begin
                if (gap_left > 0) gap_left--;
                if (!gap_started && wr_q.size() > 0) begin
                    gap_started = 1;
                    gap_left = 10;
                end
                iVblank = (gap_left == 0);
            end
            @(negedge iCLK); #1;
        end
        if (acc_edge >= 0 && first_we_cyc >= 0) lat = first_we_cyc - acc_edge;
        iWdVd = 1'b0; iStart = 1'b0; iVblank = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({oWdRdy, oPlayerPixelWe, oPDRst, oBusy, oDone, oErr} !== 6'b0 || oPlayerPixelWd !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/we/pdrst/busy/done/err=%b wd=%h, want 000000 wd=0000",
                     {oWdRdy, oPlayerPixelWe, oPDRst, oBusy, oDone, oErr}, oPlayerPixelWd);
        end
        @(posedge iCLK); #2;
        iRST = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
    endtask

    task automatic test_even();
        bit to, clr_ok, gr; int rv, gf, lat, p0, d0, bad;
        words.delete();
        words.push_back(32'h2222_1111);
        words.push_back(32'h4444_3333);
        p0 = pdrst_cnt; d0 = done_cnt;
        do_load(4, 0, 0, 0, to, clr_ok, rv, gr, gf, lat);
        checks++;
        if (to) begin errors++; $display("FAIL even_timeout: got timeout=1, want 0"); end
        checks++;
        if (!clr_ok) begin errors++; $display("FAIL even_clr_cycle: got pdrst/busy/rdy not 1/1/0 after start, want 1/1/0"); end
        checks++;
        if (pdrst_cnt - p0 != 1) begin errors++; $display("FAIL even_pdrst: got %0d pulses, want 1", pdrst_cnt - p0); end
        bad = first_bad(4);
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL even_pixels: first bad index %0d, got %0d writes, want 4 (1111 2222 3333 4444)", bad, wr_q.size()); end
        checks++;
        if (last_we_cyc - first_we_cyc != 3) begin errors++; $display("FAIL even_consecutive: got span %0d, want 3", last_we_cyc - first_we_cyc); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL even_done: got %0d pulses, want 1", done_cnt - d0); end
        checks++;
        if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL even_done_timing: got done cycle %0d, want %0d", done_cyc, last_we_cyc + 1); end
        checks++;
        if (rv != 0) begin errors++; $display("FAIL even_rdy_after_last: got %0d ready cycles, want 0", rv); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL even_latency: got %0d, want 1", lat); end
        checks++;
        if (oBusy !== 1'b1) begin errors++; $display("FAIL even_busy_in_done: got %b, want 1", oBusy); end
        @(negedge iCLK); #1;
        checks++;
        if (oBusy !== 1'b0 || oDone !== 1'b0) begin errors++; $display("FAIL even_busy_drop: got busy=%b done=%b, want 0 0", oBusy, oDone); end
        checks++;
        if (oPlayerPixelWd !== 16'h4444) begin errors++; $display("FAIL even_wd_hold: got %h, want 4444", oPlayerPixelWd); end
    endtask

    task automatic test_odd();
        bit to, clr_ok, gr; int rv, gf, lat, d0, bad;
        words.delete();
        words.push_back(32'hBBBB_AAAA);
        words.push_back(32'hDDDD_CCCC);
        d0 = done_cnt;
        do_load(3, 0, 0, 0, to, clr_ok, rv, gr, gf, lat);
        checks++;
        if (to) begin errors++; $display("FAIL odd_timeout: got timeout=1, want 0"); end
        checks++;
        if (wr_q.size() != 3) begin errors++; $display("FAIL odd_count: got %0d writes, want 3", wr_q.size()); end
        bad = first_bad(3);
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL odd_pixels: first bad index %0d, want AAAA BBBB CCCC", bad); end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != last_we_cyc + 1) begin
            errors++; $display("FAIL odd_done: got %0d pulses at cycle %0d, want 1 at %0d", done_cnt - d0, done_cyc, last_we_cyc + 1);
        end
        checks++;
        if (rv != 0) begin errors++; $display("FAIL odd_rdy_after_last: got %0d ready cycles, want 0", rv); end
    endtask

    task automatic test_vblank_gap();
        bit to, clr_ok, gr; int rv, gf, lat, bad;
        fill_random(8);
        gap_viol = 0;
        do_load(16, 2, 0, 0, to, clr_ok, rv, gr, gf, lat);
        checks++;
        if (to) begin errors++; $display("FAIL gap_timeout: got timeout=1, want 0"); end
        checks++;
        if (gap_viol != 0) begin errors++; $display("FAIL gap_writes: got %0d writes during vblank low, want 0", gap_viol); end
        checks++;
        if (gr !== 1'b0) begin errors++; $display("FAIL gap_rdy: got %b at gap end, want 0", gr); end
        checks++;
        if (gf != 4) begin errors++; $display("FAIL gap_fifo_fill: got %0d words held, want 4", gf); end
        bad = first_bad(16);
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL gap_pixels: first bad index %0d, got %0d writes, want 16", bad, wr_q.size()); end
    endtask

    task automatic test_illegal();
        bit to, clr_ok, gr; int rv, gf, lat, p0, d0, bad, lens[2];
        lens[0] = 0; lens[1] = RD + 1;
        wr_q.delete();
        iWdVd = 1'b1; iWd = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK); #1;
            checks++;
            if (oWdRdy !== 1'b0) begin errors++; $display("FAIL idle_rdy: got %b, want 0", oWdRdy); end
        end
        iWdVd = 1'b0;
        checks++;
        if (wr_q.size() != 0) begin errors++; $display("FAIL idle_writes: got %0d, want 0", wr_q.size()); end
        p0 = pdrst_cnt;
        for (int k = 0; k < 2; k++) begin
            @(posedge iCLK); #1;
            iStart = 1'b1; iLoadLen = (AW+1)'(lens[k]);
            @(posedge iCLK); #1;
            iStart = 1'b0;
            @(negedge iCLK); #1;
            checks++;
            if (oErr !== 1'b1 || oPDRst !== 1'b0 || oBusy !== 1'b0) begin
                errors++; $display("FAIL illegal_len_%0d: got err=%b pdrst=%b busy=%b, want 1 0 0", lens[k], oErr, oPDRst, oBusy);
            end
        end
        checks++;
        if (pdrst_cnt != p0) begin errors++; $display("FAIL illegal_pdrst: got %0d pulses, want 0", pdrst_cnt - p0); end
        fill_random(1);
        d0 = done_cnt;
        do_load(2, 0, 0, 0, to, clr_ok, rv, gr, gf, lat);
        checks++;
        if (!clr_ok || to) begin errors++; $display("FAIL legal_after_err_start: got clr_ok=%0d timeout=%0d, want 1 0", clr_ok, to); end
        checks++;
        if (oErr !== 1'b0) begin errors++; $display("FAIL legal_err_clear: got %b, want 0", oErr); end
        bad = first_bad(2);
        checks++;
        if (bad >= 0 || done_cnt - d0 != 1) begin errors++; $display("FAIL legal_after_err_load: bad index %0d, done pulses %0d, want -1 and 1", bad, done_cnt - d0); end
    endtask

    task automatic test_abort();
        bit to, clr_ok, gr; int rv, gf, lat, p0, d0, bad;
        fill_random(4);
        d0 = done_cnt;
        do_load(8, 0, 0, 3, to, clr_ok, rv, gr, gf, lat);
        bad = first_bad(3);
        checks++;
        if (to || bad >= 0) begin errors++; $display("FAIL abort_prefix: timeout=%0d bad index %0d, want 0 and -1", to, bad); end
        #2 iRST = 1'b1;
        #1;
        checks++;
        if ({oWdRdy, oPlayerPixelWe, oPDRst, oBusy, oDone, oErr} !== 6'b0 || oPlayerPixelWd !== '0) begin
            errors++; $display("FAIL abort_reset_outputs: got %b wd=%h, want 000000 wd=0000",
                               {oWdRdy, oPlayerPixelWe, oPDRst, oBusy, oDone, oErr}, oPlayerPixelWd);
        end
        repeat (3) @(posedge iCLK);
        #2 iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        #1;
        checks++;
        if (done_cnt != d0 || oBusy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses busy=%b, want 0 and 0", done_cnt - d0, oBusy); end
        fill_random(1);
        p0 = pdrst_cnt; d0 = done_cnt;
        do_load(2, 0, 1, 0, to, clr_ok, rv, gr, gf, lat);
        repeat (4) @(negedge iCLK);
        #1;
        checks++;
        if (!clr_ok || pdrst_cnt - p0 != 1) begin errors++; $display("FAIL restart_pdrst: got clr_ok=%0d pulses=%0d, want 1 1", clr_ok, pdrst_cnt - p0); end
        bad = first_bad(2);
        checks++;
        if (to || bad >= 0) begin errors++; $display("FAIL restart_pixels: timeout=%0d bad index %0d writes %0d, want 0 -1 2", to, bad, wr_q.size()); end
        checks++;
        if (done_cnt - d0 != 1 || oBusy !== 1'b0) begin errors++; $display("FAIL restart_done: got %0d pulses busy=%b, want 1 0", done_cnt - d0, oBusy); end
    endtask

    task automatic test_random();
        bit to, clr_ok, gr; int rv, gf, lat, d0, bad, len;
        for (int it = 0; it < 12; it++) begin
            if (it == 0) len = 1;
            else if (it == 1) len = RD;
            else len = int'($urandom_range(40, 1));
            fill_random((len + 1) / 2);
            gap_viol = 0;
            d0 = done_cnt;
            do_load(len, 1, 0, 0, to, clr_ok, rv, gr, gf, lat);
            bad = first_bad(len);
            checks++;
            if (to || bad >= 0) begin errors++; $display("FAIL rand_pixels: len %0d timeout=%0d bad index %0d writes %0d", len, to, bad, wr_q.size()); end
            checks++;
            if (done_cnt - d0 != 1 || done_cyc != last_we_cyc + 1) begin
                errors++; $display("FAIL rand_done: len %0d got %0d pulses at %0d, want 1 at %0d", len, done_cnt - d0, done_cyc, last_we_cyc + 1);
            end
            checks++;
            if (gap_viol != 0 || rv != 0) begin errors++; $display("FAIL rand_gating: len %0d got %0d blank writes %0d extra ready, want 0 0", len, gap_viol, rv); end
            @(negedge iCLK); #1;
        end
    endtask

    initial begin
        iRST = 1'b1; iStart = 1'b0; iLoadLen = '0; iWd = '0; iWdVd = 1'b0; iVblank = 1'b1;
        test_reset();
        test_even();
        test_odd();
        test_vblank_gap();
        test_illegal();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_texture_loader.md
# player_texture_loader

Writer-side companion to the player sprite draw block. It accepts packed texture words from the CPU/CSR side through a valid/ready handshake and buffers them in a small FIFO. It unpacks each word into pixels and drives the draw block's overwrite port (`PixelWd`/`PixelWe`), plus the write-address reset `PDRst`. Writes are issued only while the display is in vertical blank, so a sprite is never half-updated on screen.

## Interface
Parameters:
- `pColorDepth`, 16: bits per pixel (ARGB).
- `pRamDepth`, 2048: texture RAM depth in pixels.
- `pRamAdrsWidth`, 11: log2(`pRamDepth`).
- `pFifoDepth`, 4: input word FIFO depth; must be a power of 2.

Ports:
- `iCLK` in 1: single clock.
- `iRST` in 1: reset, asynchronous, active-high.
- `iStart` in 1: one-cycle pulse that begins a load.
- `iLoadLen` in `pRamAdrsWidth+1`: pixel count, sampled on `iStart`; legal range 1..`pRamDepth`.
- `iWd` in `2*pColorDepth`: packed pixel pair; pixel n is in the low half, pixel n+1 in the high half.
- `iWdVd` in 1: `iWd` valid.
- `oWdRdy` out 1: word accepted on an edge where `iWdVd & oWdRdy`.
- `iVblank` in 1: pixel writes are permitted only while high.
- `oPlayerPixelWd` out `pColorDepth`: pixel write data.
- `oPlayerPixelWe` out 1: pixel write strobe, one pixel per cycle.
- `oPDRst` out 1: one-cycle pulse that zeroes the draw block's write address.
- `oBusy` out 1: high while a load is in progress.
- `oDone` out 1: one-cycle pulse when the load completes.
- `oErr` out 1: sticky error flag; cleared by the next legal `iStart`.

## Operation
- **State machine**: IDLE → CLR → LOAD → DONE → IDLE.
- **IDLE**
  - `oWdRdy`=0; any `iWdVd` is ignored.
  - `iStart` with `iLoadLen`==0 or >`pRamDepth`: set `oErr`=1 and stay in IDLE; no `oPDRst` is issued.
  - `iStart` with a legal length: latch the length, clear `oErr`, go to CLR.
- **CLR** (one cycle)
  - `oPDRst`=1.
  - Flush the FIFO; clear the pixel counter and the accepted-word counter.
  - Compute words-needed = ceil(len/2), i.e. (len+1)>>1, as a `pRamAdrsWidth+1`-bit value.
  - Go to LOAD.
- **LOAD, input side**
  - `oWdRdy` = FIFO not full AND accepted-words < words-needed.
  - `oWdRdy` is decoded from registers only; it never depends on `iWdVd`.
- **LOAD, output side**
  - A half-select bit starts at low.
  - On each cycle with FIFO non-empty AND `iVblank`: register `oPlayerPixelWe`=1 and `oPlayerPixelWd` = selected half, then increment the pixel counter.
  - After a high half, pop the FIFO word and toggle back to low.
  - When the pixel counter reaches len, go to DONE. If len is odd, pop the final word after its low half; its high half is never written.
- **DONE** (one cycle): `oDone`=1, then go to IDLE.
- **`iVblank` low mid-load**: output pauses with the half-select held; on resume, output continues with the same half, in order. The FIFO may fill during the pause, which drops `oWdRdy`.
- **`iStart` while busy** (CLR, LOAD or DONE): ignored.
- **`oBusy`**: 1 in CLR, LOAD and DONE.

## Timing
- **Reset values**: all outputs 0; state IDLE; FIFO empty; counters 0. Asynchronous reset mid-load aborts immediately. There is no `oDone` and no further `oPDRst`; the next `iStart` restarts from pixel 0.
- **Start**:
  - `iStart` sampled at edge k.
  - CLR occupies the cycle after edge k, so `oPDRst`=1 and `oBusy`=1 in that cycle.
  - LOAD begins after edge k+1, and `oWdRdy` may be high from that cycle.
- **Data latency**: word accepted at edge m → earliest `oPlayerPixelWe` is the cycle after edge m+1.
- **Throughput**: one pixel per cycle while `iVblank` is high and data is available.
- **Completion**: `oDone` is high in the cycle immediately after the last `oPlayerPixelWe` cycle. `oBusy` drops one cycle after `oDone`.
- **`oPlayerPixelWd`**: holds its last value when `oPlayerPixelWe`=0.

## Test plan
- **Reset**: assert `iRST` asynchronously mid-cycle → every output is 0 immediately.
- **Even length, len=4**:
  - Stimulus: words 0x2222_1111 and 0x4444_3333, `iVblank`=1.
  - `oPDRst` pulses once.
  - `oPlayerPixelWe` is high for 4 consecutive cycles with data 1111, 2222, 3333, 4444.
  - `oDone` pulses once; `oWdRdy` stays 0 after the 2nd word.
- **Odd length, len=3**:
  - Stimulus: words 0xBBBB_AAAA and 0xDDDD_CCCC.
  - Writes are AAAA, BBBB, CCCC; DDDD is never written.
  - Exactly 3 `oPlayerPixelWe` cycles.
- **Vblank gating, len=16**:
  - Stimulus: drop `iVblank` for 10 cycles after the 1st pixel, with `iWdVd` held high.
  - No `oPlayerPixelWe` during the gap; the FIFO holds 4 words and `oWdRdy`=0.
  - On resume, data continues in order with no loss or duplication.
- **Illegal lengths**:
  - `iStart` with len=0 → `oErr`=1, no `oPDRst`, `oBusy`=0.
  - `iStart` with len=2049 → same response.
  - A following `iStart` with len=2 → `oErr` clears and the load completes.
  - `iWdVd` while IDLE → `oWdRdy`=0 and no writes.
- **Abort**:
  - Stimulus: assert `iRST` after 3 of 8 pixels; then start again with len=2.
  - Outputs are cleared and no `oDone` occurs for the aborted load.
  - The restart produces `oPDRst` then 2 writes; a busy-time `iStart` is ignored.
